// File: rtl/ctrl_pkg.sv
// Shared opcode constants, ALU operation encodings and the control bundle
// carried through the ID/EX, MEM and MEM/WB stage registers.
// Pure declarations; no timing or flow control of its own.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_BNE   = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_AND   = 3'b101;
  localparam logic [2:0] ALU_OR    = 3'b110;
  localparam logic [2:0] ALU_XOR   = 3'b111;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       reg_write;
    logic       mem_to_reg;
    logic       jal;
    logic       jump;
    logic       ext_op;
    logic       branch_ne;
    logic       jump_reg;
  } ctrl_t;

  // All-zero bundle: guarantees no register or memory write.
  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic       valid;
    ctrl_t      ctl;
    logic [4:0] dest;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // True when a load held in stage s writes a register the ID instruction reads.
  function automatic logic load_hits(input stage_t s,
                                     input logic [4:0] rs, input logic use_rs,
                                     input logic [4:0] rt, input logic use_rt);
    logic hit_rs;
    logic hit_rt;
    hit_rs = use_rs && (rs != 5'd0) && (s.dest == rs);
    hit_rt = use_rt && (rt != 5'd0) && (s.dest == rt);
    return s.valid && s.ctl.mem_read && (hit_rs || hit_rt);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purpose: combinational opcode/funct to control-bundle table.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; optional jr/jalr decode under CTRL_PIPE_JR_EN.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctl
);

`ifndef CTRL_PIPE_JR_EN
  logic unused_funct;
  assign unused_funct = ^funct;
`endif

  // Main decode table; unknown opcodes fall through to the bubble.
  always_comb begin
    ctl = CTRL_BUBBLE;
    case (op)
      OP_RTYPE: begin
        ctl.reg_dst   = 1'b1;
        ctl.alu_op    = ALU_RTYPE;
        ctl.reg_write = 1'b1;
`ifdef CTRL_PIPE_JR_EN
        if (funct == FN_JR) begin
          ctl.jump      = 1'b1;
          ctl.jump_reg  = 1'b1;
          ctl.reg_write = 1'b0;
        end else if (funct == FN_JALR) begin
          ctl.jump      = 1'b1;
          ctl.jump_reg  = 1'b1;
          ctl.jal       = 1'b1;
        end
`endif
      end
      OP_J: ctl.jump = 1'b1;
      OP_JAL: begin
        ctl.jump      = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.jal       = 1'b1;
      end
      OP_BEQ: begin
        ctl.branch = 1'b1;
        ctl.alu_op = ALU_SUB;
        ctl.ext_op = 1'b1;
      end
      OP_BNE: begin
        ctl.branch    = 1'b1;
        ctl.alu_op    = ALU_BNE;
        ctl.ext_op    = 1'b1;
        ctl.branch_ne = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        ctl.alu_src   = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.ext_op    = (op == OP_ADDI) || (op == OP_SLTI);
        ctl.alu_op    = (op == OP_ADDI) ? ALU_ADD :
                        (op == OP_SLTI) ? ALU_SLT :
                        (op == OP_ANDI) ? ALU_AND :
                        (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LW: begin
        ctl.mem_read   = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.alu_src    = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.ext_op     = 1'b1;
      end
      OP_SW: begin
        ctl.mem_write = 1'b1;
        ctl.alu_src   = 1'b1;
        ctl.ext_op    = 1'b1;
      end
      default: ctl = CTRL_BUBBLE;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Purpose: decode ID control, carry it through EX/MEM/WB, insert flush and load-use bubbles.
// Latency: ex_* at N+1, mem_* at N+2, wb_* at N+2+MEM_STAGES; optional jr/jalr via CTRL_PIPE_JR_EN.
// Backpressure: mem_stall freezes every stage; hazard_stall holds PC and IF/ID.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int MEM_STAGES = 1,
  parameter int ALUOP_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [5:0]         id_op,
  input  logic [5:0]         id_funct,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               flush,
  input  logic               mem_stall,
  output logic               id_jump,
  output logic               id_ext_op,
  output logic               id_branch_ne,
  output logic               id_jump_reg,
  output logic               hazard_stall,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_branch,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic               wb_jal
);

  ctrl_t  dec;
  stage_t id_stage;
  stage_t idex_q;
  stage_t mem_q [1:MEM_STAGES];
  stage_t wb_q;
  logic   reads_rs;
  logic   reads_rt;
  logic   load_use;
  logic   id_live;
  logic   unused_wb;

  ctrl_decode u_decode (
    .op    (id_op),
    .funct (id_funct),
    .ctl   (dec)
  );

  assign id_stage.valid = id_valid;
  assign id_stage.ctl   = id_valid ? dec : CTRL_BUBBLE;
  assign id_stage.dest  = id_stage.ctl.mem_read ? id_rt : 5'd0;

  // A flushed or empty ID slot must not steer the fetch path.
  assign id_live      = id_valid && !flush;
  assign id_jump      = id_live && dec.jump;
  assign id_ext_op    = id_live && dec.ext_op;
  assign id_branch_ne = id_live && dec.branch_ne;
`ifdef CTRL_PIPE_JR_EN
  assign id_jump_reg  = id_live && dec.jump_reg;
`else
  assign id_jump_reg  = 1'b0;
`endif

  // Compare ID sources against every load whose data is not yet back by ID time.
  always_comb begin
    reads_rs = id_valid && (id_op != OP_J) && (id_op != OP_JAL);
    reads_rt = id_valid && ((id_op == OP_RTYPE) || (id_op == OP_BEQ) ||
                            (id_op == OP_BNE)   || (id_op == OP_SW));
    load_use = load_hits(idex_q, id_rs, reads_rs, id_rt, reads_rt);
    for (int i = 1; i < MEM_STAGES; i++) begin
      load_use = load_use || load_hits(mem_q[i], id_rs, reads_rs, id_rt, reads_rt);
    end
  end

  // Under a freeze the held pipeline keeps the hazard stable; a flush kills the reader anyway.
  assign hazard_stall = !rst && load_use && (mem_stall || !flush);

  // Stage registers: reset clears, mem_stall holds, flush/hazard inject a bubble into ID/EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= STAGE_BUBBLE;
      for (int i = 1; i <= MEM_STAGES; i++) mem_q[i] <= STAGE_BUBBLE;
      wb_q   <= STAGE_BUBBLE;
    end else if (!mem_stall) begin
      idex_q   <= (flush || load_use) ? STAGE_BUBBLE : id_stage;
      mem_q[1] <= idex_q;
      for (int i = 2; i <= MEM_STAGES; i++) mem_q[i] <= mem_q[i-1];
      wb_q     <= mem_q[MEM_STAGES];
    end
  end

  assign ex_reg_dst    = idex_q.ctl.reg_dst;
  assign ex_alu_src    = idex_q.ctl.alu_src;
  assign ex_alu_op     = ALUOP_W'(idex_q.ctl.alu_op);
  assign mem_read      = mem_q[1].ctl.mem_read;
  assign mem_write     = mem_q[1].ctl.mem_write;
  assign mem_branch    = mem_q[1].ctl.branch;
  assign wb_reg_write  = wb_q.ctl.reg_write;
  assign wb_mem_to_reg = wb_q.ctl.mem_to_reg;
  assign wb_jal        = wb_q.ctl.jal;

  // Remaining WB fields are carried for debug visibility only.
  assign unused_wb = ^wb_q;

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised successor to the combinational main-control decoder of the 5-stage MIPS core.
- Decodes the ID-stage opcode into the control bundle and carries that bundle through EX, MEM and WB in its own pipeline registers.
- Owns bubble insertion for flush and load-use hazards, and honours a global memory freeze.
- Memory depth is configurable. Sits between the IF/ID register and the datapath stage muxes.

Parameters:
- MEM_STAGES, 1, number of MEM pipeline stages (1..4); sets ID->WB latency.
- ALUOP_W, 3, width of the ALU operation code.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-high
- id_valid  input  1  IF/ID holds a real instruction
- id_op  input  6  opcode [31:26]
- id_funct  input  6  funct [5:0]
- id_rs  input  5  source register rs
- id_rt  input  5  source register rt
- flush  input  1  kill the ID instruction (taken branch/jump), active-high
- mem_stall  input  1  global freeze from the data cache
- id_jump  output  1  combinational, ID stage
- id_ext_op  output  1  combinational, ID stage
- id_branch_ne  output  1  combinational; 1 = bne, 0 = beq
- hazard_stall  output  1  hold PC and IF/ID
- ex_reg_dst  output  1  EX-stage control
- ex_alu_src  output  1  EX-stage control
- ex_alu_op  output  ALUOP_W  EX-stage control
- mem_read  output  1  first MEM stage
- mem_write  output  1  first MEM stage
- mem_branch  output  1  first MEM stage
- wb_reg_write  output  1  WB stage
- wb_mem_to_reg  output  1  WB stage
- wb_jal  output  1  WB stage

Behaviour:
- Decode table (same as the current decoder):
  - R-type 00: RegDst=1, ALUOp=010, RegWrite=1.
  - j 02: Jump=1.
  - jal 03: Jump=1, RegWrite=1, Jal=1.
  - beq 04: Branch=1, ALUOp=001, ExtOp=1.
  - bne 05: Branch=1, ALUOp=011, ExtOp=1.
  - addi 08: ALUSrc=1, RegWrite=1, ExtOp=1, ALUOp=000.
  - slti 0a: ALUOp=100, ALUSrc=1, RegWrite=1, ExtOp=1.
  - andi 0c / ori 0d / xori 0e: ALUOp=101/110/111, ALUSrc=1, RegWrite=1, ExtOp=0.
  - lw 23: MemRead=1, MemtoReg=1, ALUSrc=1, RegWrite=1, ExtOp=1.
  - sw 2b: MemWrite=1, ALUSrc=1, ExtOp=1.
  - Unknown opcode or id_valid=0: all-zero bubble.
- Pipeline: ID/EX reg -> MEM_STAGES MEM regs -> MEM/WB reg.
  - ex_* come from ID/EX; mem_* from MEM reg 1; wb_* from MEM/WB.
  - Latency: decode in cycle N reaches ex_* at N+1, mem_* at N+2, wb_* at N+2+MEM_STAGES.
  - Each stage also carries valid and the load destination (id_rt when MemRead).
- Load-use hazard:
  - Condition: ID instruction reads rs (all except j/jal), or reads rt (R-type, beq, bne, sw).
  - Comparison targets: a valid load in ID/EX or in MEM regs 1..MEM_STAGES-1 whose dest equals that source.
  - Register 0 never matches.
- Per-cycle priority: rst > mem_stall > flush > hazard.
  - rst: every stage register cleared to bubble; all registered outputs 0; hazard_stall=0.
  - mem_stall=1: all pipeline registers hold. hazard_stall = computed hazard (held state gives a stable value).
  - flush=1: bubble written into ID/EX; hazard_stall=0.
  - hazard (no flush): bubble into ID/EX; hazard_stall=1; downstream stages advance.
  - Otherwise: decoded bundle into ID/EX; all stages shift.
- id_jump, id_ext_op and id_branch_ne are combinational from id_op, forced to 0 when id_valid=0 or flush=1.
- Bubbles produce zero writes: MemWrite=0 and RegWrite=0 are guaranteed for every bubble.
- Reset mid-stream discards all in-flight control; there is no partial drain.

Optional Feature:
- Macro CTRL_PIPE_JR_EN.
- Defined: op 00 with funct 08 (jr) asserts id_jump and a new output id_jump_reg, with RegWrite=0. Funct 09 (jalr) additionally sets RegWrite=1, RegDst=1, Jal=1. jr/jalr count as reading rs for hazard detection.
- Undefined: funct is ignored, jr/jalr decode as ordinary R-type, and id_jump_reg is tied to 0.

Decomposition:
- Package ctrl_pkg:
  - opcode constants (OP_RTYPE, OP_J, OP_LW, ...);
  - ALUOp encodings;
  - control-bundle struct typedef plus bundle constant CTRL_BUBBLE.
- Sub-module ctrl_decode: the pure combinational op/funct -> bundle table, reused from the current decoder.
- ctrl_pipe contains the stage registers, the hazard compare and the priority logic.

Test Plan:
- Reset: rst=1 for 2 cycles mid-stream (lw, add in flight) -> all ex_/mem_/wb_ outputs 0 the cycle after; nothing reaches WB.
- Plain sequence, MEM_STAGES=1: addi in cycle 0 -> ex_alu_src=1 at cycle 1; wb_reg_write=1 at cycle 3, wb_mem_to_reg=0.
- Load-use: lw $5 followed by add $6,$5,$1 -> hazard_stall=1 for 1 cycle, a single bubble in EX; with MEM_STAGES=2 the stall lasts 2 cycles.
- Load into $0 followed by a reader of $0 -> no stall.
- Flush and hazard in the same cycle -> hazard_stall=0, bubble in EX, no extra stall cycle.
- mem_stall held 3 cycles with a sw in MEM -> mem_write stays 1 and all outputs stay frozen; sequence resumes intact.
- With CTRL_PIPE_JR_EN: jalr (op 00, funct 09) -> id_jump_reg=1, wb_jal=1 and wb_reg_write=1 at N+2+MEM_STAGES. Without the macro the same instruction decodes as R-type.
